// File: rtl/bombman_pkg.sv
// Shared grid geometry, bomb-state encodings and cell addressing for the
// bomb pipeline stages.
package bombman_pkg;

  localparam int GRID_W          = 10;
  localparam int GRID_CELLS      = GRID_W * GRID_W;
  localparam int AREA_MIN        = 1;
  localparam int AREA_MAX        = 8;
  localparam int FLAME_TICKS_DEF = 2;
  localparam int TW              = 2;

  localparam logic [1:0] BOMB_NONE = 2'b00;
  localparam logic [1:0] BOMB_EXPL = 2'b11;

  function automatic int cell_idx(input int x, input int y);
    return GRID_W * x + y;
  endfunction

  function automatic logic in_area(input int x, input int y);
    return (x >= AREA_MIN) && (x <= AREA_MAX) && (y >= AREA_MIN) && (y <= AREA_MAX);
  endfunction

endpackage

// File: rtl/blast_map_cell.sv
// One play-area cell: flame hold timer plus a one-tick chain-request flag
// for a fused bomb caught by fresh flame.
module flame_cell
  import bombman_pkg::*;
#(
  parameter int FLAME_TICKS = FLAME_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ignite,
  input  logic [1:0] bomb_state,
  output logic       lit,
  output logic       lit_next,
  output logic       chain
);

  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_s;
  logic          lit_r;
  logic          chain_r;
  logic          chain_s;

  // Next timer value: a fresh ignition reloads even a running timer.
  always_comb begin
    timer_s = timer_r;
    if (ignite) begin
      timer_s = TW'(FLAME_TICKS);
    end else if (timer_r != {TW{1'b0}}) begin
      timer_s = timer_r - TW'(1'b1);
    end else begin
      timer_s = timer_r;
    end
  end

  assign lit_next = (timer_s != {TW{1'b0}});
  assign chain_s  = ignite && (bomb_state != BOMB_NONE) && (bomb_state != BOMB_EXPL);

  // Timer, lit decode and chain flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= {TW{1'b0}};
      lit_r   <= 1'b0;
      chain_r <= 1'b0;
    end else begin
      timer_r <= timer_s;
      lit_r   <= lit_next;
      chain_r <= chain_s;
    end
  end

  assign lit   = lit_r;
  assign chain = chain_r;

endmodule

// File: rtl/blast_map.sv
// Cross-shaped flame generator: turns exploding bombs into a held flame map,
// chain requests for fused bombs in the blast, and a running blast count.
module blast_map
  import bombman_pkg::*;
#(
  parameter int RADIUS      = 2,
  parameter int FLAME_TICKS = FLAME_TICKS_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                  bombClk,
  input  logic                  rst,
  input  logic [GRID_CELLS-1:0] i_curBombMap_0,
  input  logic [GRID_CELLS-1:0] i_curBombMap_1,
  input  logic [GRID_CELLS-1:0] i_wallMap,
  output logic [GRID_CELLS-1:0] o_flameMap,
  output logic [GRID_CELLS-1:0] o_chainMap,
  output logic                  o_flameActive,
  output logic [CNT_W-1:0]      o_blastCount
);

  function automatic int dir_dx(input int dr);
    case (dr)
      0:       return 32'sd1;
      1:       return -32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic int dir_dy(input int dr);
    case (dr)
      2:       return 32'sd1;
      3:       return -32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  // Cells a flame crosses to reach (x,y) from d steps back along dr, target included.
  function automatic logic [GRID_CELLS-1:0] path_mask(input int x, input int y, input int dr, input int d);
    logic [GRID_CELLS-1:0] m;
    m = '0;
    for (int k = 0; k < d; k++) begin
      m[cell_idx(x - k * dir_dx(dr), y - k * dir_dy(dr))] = 1'b1;
    end
    return m;
  endfunction

  logic [GRID_CELLS-1:0] expl_s;
  logic [GRID_CELLS-1:0] ignite_s;
  logic [GRID_CELLS-1:0] lit_next_s;
  logic [GRID_CELLS-1:0] flame_s;
  logic [GRID_CELLS-1:0] chain_s;
  logic [GRID_CELLS-1:0] unused_border_s;
  logic [CNT_W-1:0]      pop_s;
  logic [CNT_W-1:0]      blast_count_r;
  logic                  flame_active_r;

  for (genvar x = 0; x < GRID_W; x++) begin : g_x
    for (genvar y = 0; y < GRID_W; y++) begin : g_y
      localparam int C = cell_idx(x, y);
      if (in_area(x, y)) begin : g_play
        logic [4*RADIUS-1:0] term_s;
        // Target-centric view: look back along each arm for a bomb whose path is wall-free.
        for (genvar dr = 0; dr < 4; dr++) begin : g_dir
          for (genvar d = 1; d <= RADIUS; d++) begin : g_dist
            localparam int SX = x - d * dir_dx(dr);
            localparam int SY = y - d * dir_dy(dr);
            if (in_area(SX, SY)) begin : g_src
              localparam logic [GRID_CELLS-1:0] PATH = path_mask(x, y, dr, d);
              assign term_s[dr*RADIUS+d-1] = expl_s[cell_idx(SX, SY)] & ~|(i_wallMap & PATH);
            end else begin : g_nosrc
              assign term_s[dr*RADIUS+d-1] = 1'b0;
            end
          end
        end
        assign expl_s[C]          = i_curBombMap_1[C] & i_curBombMap_0[C] & ~i_wallMap[C];
        assign ignite_s[C]        = expl_s[C] | (|term_s);
        assign unused_border_s[C] = 1'b0;
        flame_cell #(.FLAME_TICKS(FLAME_TICKS)) u_cell (
          .clk        (bombClk),
          .rst        (rst),
          .ignite     (ignite_s[C]),
          .bomb_state ({i_curBombMap_1[C], i_curBombMap_0[C]}),
          .lit        (flame_s[C]),
          .lit_next   (lit_next_s[C]),
          .chain      (chain_s[C])
        );
      end else begin : g_border
        assign expl_s[C]          = 1'b0;
        assign ignite_s[C]        = 1'b0;
        assign lit_next_s[C]      = 1'b0;
        assign flame_s[C]         = 1'b0;
        assign chain_s[C]         = 1'b0;
        assign unused_border_s[C] = i_curBombMap_1[C] ^ i_curBombMap_0[C] ^ i_wallMap[C];
      end
    end
  end

  // Number of bombs exploding on this edge.
  always_comb begin
    pop_s = {CNT_W{1'b0}};
    for (int i = 0; i < GRID_CELLS; i++) begin
      pop_s = pop_s + CNT_W'(expl_s[i]);
    end
  end

  // Wrapping blast counter and registered flame-active flag.
  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      blast_count_r  <= {CNT_W{1'b0}};
      flame_active_r <= 1'b0;
    end else begin
      blast_count_r  <= blast_count_r + pop_s;
      flame_active_r <= |lit_next_s;
    end
  end

  assign o_flameMap    = flame_s;
  assign o_chainMap    = chain_s;
  assign o_flameActive = flame_active_r;
  assign o_blastCount  = blast_count_r;

endmodule
